// File: rtl/apb_pkg.sv
// Shared definitions for the apb_master register block.
//   - default sizes for bus and bank geometry
//   - FSM state type
//   - one-hot helper used by the bank-select decode
package apb_pkg;

    localparam int DEF_NUM_SLAVES = 4;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 16;

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } state_t;

    // Callers zero-extend their select vector to 32 bits, so any bank count up to 32 works.
    function automatic logic is_onehot(input logic [31:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB4 bus bundle between the system requester and the apb_master register block.
// Signals:
//   psel     one-hot bank select        penable  access-phase indicator
//   paddr    byte address               pwrite   1 = write, 0 = read
//   pprot    protection attributes      pwdata   write data
//   pstrb    write byte-lane enables    prdata   read data
//   pready   transfer-complete strobe   pslverr  transfer error, valid with pready
// Modports: master (requester side), slave (register block side).
interface apb_master_if #(
    parameter int NUM_SLAVES = apb_pkg::DEF_NUM_SLAVES,
    parameter int ADDR_WIDTH = apb_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = apb_pkg::DEF_DATA_WIDTH
) ();

    logic [NUM_SLAVES-1:0]   psel;
    logic                    penable;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    pwrite;
    logic [2:0]              pprot;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pprot, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pprot, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_reg_bank.sv
// One word-addressed register bank with a byte-strobed write port and a
// registered read port.
// Ports:
//   pclk, preset  clock and synchronous active-high reset (clears all words and rdata)
//   we            write enable; lanes selected by wstrb
//   rd_load       load rdata from the addressed word
//   rd_clr        clear rdata (another bank or an error now owns the read bus)
//   idx           word index
//   wdata, wstrb  write data and byte-lane enables
//   rdata         registered read data; zero unless this bank served the last read
module apb_reg_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       we,
    input  logic                       rd_load,
    input  logic                       rd_clr,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                for (int i = 0; i < DATA_WIDTH/8; i++) begin
                    if (wstrb[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            if (rd_load) begin
                rdata <= mem[idx];
            end else if (rd_clr) begin
                rdata <= '0;
            end
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB4 completer holding NUM_SLAVES independent register banks, one wait state
// per transfer. Bank chosen by one-hot psel; word index from paddr.
// Ports:
//   pclk    clock
//   preset  synchronous active-high reset; aborts any transfer in flight
//   bus     apb_master_if.slave bundle (psel/penable/paddr/pwrite/pprot/pwdata/pstrb in,
//           prdata/pready/pslverr out, all outputs registered)
// Build option: APB_PROT_CHECK_EN makes an unprivileged write (pprot[0]=0) to the
// last bank an error; without it pprot is ignored.
//
// state | meaning
// IDLE  | waiting for an access phase; transfer executes on the edge that leaves IDLE
// DONE  | transfer completed; held access phase is absorbed until penable or psel drops
module apb_master
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic        pclk,
    input  logic        preset,
    apb_master_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t                  state;
    logic                    pready_q;
    logic                    pslverr_q;
    logic                    exec;
    logic                    sel_err;
    logic                    addr_err;
    logic                    prot_err;
    logic                    err;
    logic [IDX_W-1:0]        idx;
    logic [NUM_SLAVES-1:0]   bank_we;
    logic [NUM_SLAVES-1:0]   bank_rd_load;
    logic [NUM_SLAVES-1:0]   bank_rd_clr;
    logic [DATA_WIDTH-1:0]   bank_rdata [NUM_SLAVES];
    logic [DATA_WIDTH-1:0]   prdata_or;

    assign idx      = bus.paddr[IDX_W+1:2];
    assign sel_err  = !is_onehot(32'(bus.psel));
    assign addr_err = (bus.paddr[1:0] != 2'b00) ||
                      (bus.paddr[ADDR_WIDTH-1:IDX_W+2] != '0);

`ifdef APB_PROT_CHECK_EN
    logic unused_prot;
    assign unused_prot = ^bus.pprot[2:1];
    assign prot_err    = bus.pwrite && bus.psel[NUM_SLAVES-1] && !bus.pprot[0];
`else
    logic unused_prot;
    assign unused_prot = ^bus.pprot;
    assign prot_err    = 1'b0;
`endif

    assign err  = sel_err || addr_err || prot_err;
    assign exec = (state == IDLE) && (bus.psel != '0) && bus.penable;

    // Each bank keeps its own read register; only the bank that served the most
    // recent read holds non-zero data, so the output is a plain OR of registers.
    always_comb begin
        bank_we      = '0;
        bank_rd_load = '0;
        bank_rd_clr  = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            bank_we[s]      = exec && !err && bus.pwrite && bus.psel[s];
            bank_rd_load[s] = exec && !err && !bus.pwrite && bus.psel[s];
            bank_rd_clr[s]  = exec && (err || (!bus.pwrite && !bus.psel[s]));
        end
    end

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_bank
        apb_reg_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_bank (
            .pclk    (pclk),
            .preset  (preset),
            .we      (bank_we[g]),
            .rd_load (bank_rd_load[g]),
            .rd_clr  (bank_rd_clr[g]),
            .idx     (idx),
            .wdata   (bus.pwdata),
            .wstrb   (bus.pstrb),
            .rdata   (bank_rdata[g])
        );
    end

    always_comb begin
        prdata_or = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            prdata_or = prdata_or | bank_rdata[s];
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (exec) begin
                        state     <= DONE;
                        pready_q  <= 1'b1;
                        pslverr_q <= err;
                    end else begin
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                    end
                end
                DONE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    if (!bus.penable || (bus.psel == '0)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prdata  = prdata_or;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

    logic pclk = 1'b0;
    logic preset;

    always #5 pclk = ~pclk;

    apb_master_if bus ();

    apb_master dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [4][16];
    logic [31:0] exp_prdata;

`ifdef APB_PROT_CHECK_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [3:0] sel, input logic [31:0] addr,
                                     input bit wr, input logic [2:0] prot);
        int ones;
        ones = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) ones++;
        if (ones != 1) return 1'b1;
        if (addr % 4 != 0) return 1'b1;
        if (addr >= 64) return 1'b1;
        if (PROT_ON && wr && sel[3] && !prot[0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bank_of(input logic [3:0] sel);
        for (int i = 0; i < 4; i++) if (sel[i]) return i;
        return 0;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 16; w++)
                mem[b][w] = 32'h0;
        exp_prdata = 32'h0;
    endtask

    // One complete transfer: setup cycle, then penable held for 'hold' cycles.
    task automatic xfer(input logic [3:0] sel, input logic [31:0] addr, input bit wr,
                        input logic [31:0] wd, input logic [3:0] st, input logic [2:0] prot,
                        input int hold, input string tag,
                        output logic [31:0] rd, output logic rerr);
        bit   e;
        int   b;
        int   w;
        int   pulses;
        logic seen_err;
        logic [31:0] seen_rd;

        e = model_err(sel, addr, wr, prot);
        if (e) begin
            exp_prdata = 32'h0;
        end else begin
            b = bank_of(sel);
            w = int'(addr / 4);
            if (wr) begin
                for (int i = 0; i < 4; i++)
                    if (st[i]) mem[b][w][8*i +: 8] = wd[8*i +: 8];
            end else begin
                exp_prdata = mem[b][w];
            end
        end

        seen_err = 1'bx;
        seen_rd  = 32'hx;
        pulses   = 0;

        @(negedge pclk);
        bus.psel    = sel;
        bus.penable = 1'b0;
        bus.paddr   = addr;
        bus.pwrite  = wr;
        bus.pwdata  = wd;
        bus.pstrb   = st;
        bus.pprot   = prot;
        @(negedge pclk);
        bus.penable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge pclk);
            if (bus.pready === 1'b1) begin
                pulses++;
                seen_err = bus.pslverr;
                seen_rd  = bus.prdata;
            end
        end
        bus.psel    = 4'b0000;
        bus.penable = 1'b0;
        @(negedge pclk);
        if (bus.pready === 1'b1) pulses++;

        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_pslverr"}, {31'h0, seen_err}, {31'h0, e});
        check({tag, "_prdata"}, seen_rd, exp_prdata);
        check({tag, "_prdata_hold"}, bus.prdata, exp_prdata);
        rd   = seen_rd;
        rerr = seen_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        re;
        logic [3:0]  sel;
        logic [31:0] addr;
        int          r;

        preset      = 1'b1;
        bus.psel    = 4'b0000;
        bus.penable = 1'b0;
        bus.paddr   = 32'h0;
        bus.pwrite  = 1'b0;
        bus.pwdata  = 32'h0;
        bus.pstrb   = 4'h0;
        bus.pprot   = 3'b000;
        model_clear();

        repeat (3) @(negedge pclk);
        check("rst_pready", {31'h0, bus.pready}, 32'h0);
        check("rst_pslverr", {31'h0, bus.pslverr}, 32'h0);
        check("rst_prdata", bus.prdata, 32'h0);
        preset = 1'b0;
        @(negedge pclk);

        xfer(4'b0001, 32'h4, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, 1, "w_b0", rd, re);
        xfer(4'b0001, 32'h4, 1'b0, 32'h0, 4'h0, 3'b001, 1, "r_b0", rd, re);
        check("r_b0_val", rd, 32'hDEADBEEF);

        xfer(4'b0010, 32'h8, 1'b1, 32'hCAFEBABE, 4'hF, 3'b001, 1, "w_b1", rd, re);
        xfer(4'b1000, 32'h10, 1'b1, 32'hABCDEF12, 4'hF, 3'b001, 1, "w_b3", rd, re);
        xfer(4'b0010, 32'h8, 1'b0, 32'h0, 4'h0, 3'b000, 1, "r_b1", rd, re);
        check("r_b1_val", rd, 32'hCAFEBABE);
        xfer(4'b1000, 32'h10, 1'b0, 32'h0, 4'h0, 3'b000, 1, "r_b3", rd, re);
        check("r_b3_val", rd, 32'hABCDEF12);
        xfer(4'b0001, 32'h8, 1'b0, 32'h0, 4'h0, 3'b000, 1, "r_b0_8", rd, re);
        check("r_b0_8_val", rd, 32'h0);

        xfer(4'b0100, 32'hC, 1'b1, 32'h12345678, 4'b1010, 3'b001, 1, "w_strb", rd, re);
        xfer(4'b0100, 32'hC, 1'b0, 32'hFFFFFFFF, 4'h0, 3'b001, 1, "r_strb", rd, re);
        check("r_strb_val", rd, 32'h12005600);

        xfer(4'b0011, 32'h4, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, 1, "e_sel_w", rd, re);
        check("e_sel_w_err", {31'h0, re}, 32'h1);
        xfer(4'b0011, 32'h4, 1'b0, 32'h0, 4'h0, 3'b001, 1, "e_sel_r", rd, re);
        check("e_sel_r_val", rd, 32'h0);
        xfer(4'b0001, 32'h6, 1'b1, 32'h11111111, 4'hF, 3'b001, 1, "e_align_w", rd, re);
        check("e_align_w_err", {31'h0, re}, 32'h1);
        xfer(4'b0001, 32'h100, 1'b1, 32'h22222222, 4'hF, 3'b001, 1, "e_range_w", rd, re);
        check("e_range_w_err", {31'h0, re}, 32'h1);
        xfer(4'b0001, 32'h4, 1'b0, 32'h0, 4'h0, 3'b001, 1, "r_after_err", rd, re);
        check("r_after_err_val", rd, 32'hDEADBEEF);
        xfer(4'b0001, 32'h6, 1'b0, 32'h0, 4'h0, 3'b001, 1, "e_align_r", rd, re);
        check("e_align_r_val", rd, 32'h0);

        xfer(4'b0100, 32'h20, 1'b1, 32'h0F0F0F0F, 4'hF, 3'b001, 4, "held_w", rd, re);
        xfer(4'b0100, 32'h20, 1'b0, 32'h0, 4'h0, 3'b001, 4, "held_r", rd, re);
        check("held_r_val", rd, 32'h0F0F0F0F);

        xfer(4'b1000, 32'h14, 1'b1, 32'h77777777, 4'hF, 3'b000, 1, "prot_w", rd, re);
        check("prot_w_err", {31'h0, re}, {31'h0, PROT_ON});
        xfer(4'b1000, 32'h14, 1'b0, 32'h0, 4'h0, 3'b000, 1, "prot_r", rd, re);
        check("prot_r_val", rd, PROT_ON ? 32'h0 : 32'h77777777);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) sel = 4'(1 << (r % 4));
            else       sel = 4'($urandom_range(1, 15));
            r = $urandom_range(0, 9);
            if (r < 8)       addr = 32'($urandom_range(0, 15) * 4);
            else if (r == 8) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else             addr = 32'h40 << $urandom_range(0, 25);
            xfer(sel, addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), $urandom_range(1, 3), "rand", rd, re);
        end

        @(negedge pclk);
        bus.psel    = 4'b0001;
        bus.paddr   = 32'h4;
        bus.pwrite  = 1'b1;
        bus.pwdata  = 32'h55AA55AA;
        bus.pstrb   = 4'hF;
        bus.penable = 1'b0;
        @(negedge pclk);
        bus.penable = 1'b1;
        preset      = 1'b1;
        @(negedge pclk);
        check("mid_rst_pready0", {31'h0, bus.pready}, 32'h0);
        preset      = 1'b0;
        bus.psel    = 4'b0000;
        bus.penable = 1'b0;
        @(negedge pclk);
        check("mid_rst_pready1", {31'h0, bus.pready}, 32'h0);
        check("mid_rst_prdata", bus.prdata, 32'h0);
        model_clear();
        xfer(4'b0001, 32'h4, 1'b0, 32'h0, 4'h0, 3'b001, 1, "mid_rst_r0", rd, re);
        check("mid_rst_r0_val", rd, 32'h0);
        xfer(4'b0010, 32'h8, 1'b0, 32'h0, 4'h0, 3'b001, 1, "mid_rst_r1", rd, re);
        check("mid_rst_r1_val", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
